// File: rtl/dht11_read_scheduler.sv
// Schedules DHT11 reads: coalesces manual/auto requests, runs one attempt at a time with timeout,
// checksum validation, bounded retries and an inter-read gap; latches the last good reading.
module dht11_read_scheduler #(
  parameter int unsigned MIN_GAP_MS     = 2000,
  parameter int unsigned AUTO_PERIOD_MS = 2000,
  parameter int unsigned TIMEOUT_MS     = 50,
  parameter int unsigned RETRY_MAX      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1us,
  input  logic        req_manual,
  input  logic        auto_en,
  output logic        unit_start,
  input  logic        unit_done,
  input  logic        unit_valid,
  input  logic [39:0] unit_data,
  output logic [7:0]  humidity_int,
  output logic [7:0]  humidity_dec,
  output logic [7:0]  temp_int,
  output logic [7:0]  temp_dec,
  output logic        data_valid,
  output logic        fault,
  output logic [7:0]  err_count,
  output logic        busy,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  presc_q, presc_d;
  logic [15:0] auto_q, auto_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] gap_q, gap_d;
  logic        pending_q, pending_d;
  logic [7:0]  retry_q, retry_d;
  logic [39:0] cap_data_q, cap_data_d;
  logic        cap_valid_q, cap_valid_d;
  logic [7:0]  hi_q, hi_d, hd_q, hd_d, ti_q, ti_d, td_q, td_d;
  logic        dv_q, dv_d;
  logic        fault_q, fault_d;
  logic [7:0]  err_q, err_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;

  logic        ms_tick;
  logic        auto_fire;
  logic [7:0]  csum_calc;
  logic        check_ok;

  assign ms_tick   = tick_1us && (presc_q == 10'd999);
  assign auto_fire = auto_en && ms_tick && (auto_q == 16'(AUTO_PERIOD_MS - 1));
  assign csum_calc = cap_data_q[39:32] + cap_data_q[31:24] + cap_data_q[23:16] + cap_data_q[15:8];
  assign check_ok  = cap_valid_q && (csum_calc == cap_data_q[7:0]);

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    auto_d      = auto_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    pending_d   = pending_q;
    retry_d     = retry_q;
    cap_data_d  = cap_data_q;
    cap_valid_d = cap_valid_q;
    hi_d        = hi_q;
    hd_d        = hd_q;
    ti_d        = ti_q;
    td_d        = td_q;
    dv_d        = dv_q;
    fault_d     = fault_q;
    err_d       = err_q;

    if (tick_1us) presc_d = (presc_q == 10'd999) ? 10'd0 : presc_q + 10'd1;

    if (!auto_en)      auto_d = 16'd0;
    else if (auto_fire) auto_d = 16'd0;
    else if (ms_tick)   auto_d = auto_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (pending_q) state_d = S_START;
      end
      S_START: begin
        pending_d = 1'b0;
        tmo_d     = 16'd0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A frame landing on the timeout cycle still counts as a response.
        if (unit_done) begin
          cap_data_d  = unit_data;
          cap_valid_d = unit_valid;
          state_d     = S_CHECK;
        end else if (ms_tick) begin
          if (tmo_q == 16'(TIMEOUT_MS - 1)) begin
            cap_valid_d = 1'b0;
            state_d     = S_CHECK;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
      end
      S_CHECK: begin
        gap_d   = 16'd0;
        state_d = S_HOLD;
        if (check_ok) begin
          hi_d    = cap_data_q[39:32];
          hd_d    = cap_data_q[31:24];
          ti_d    = cap_data_q[23:16];
          td_d    = cap_data_q[15:8];
          dv_d    = 1'b1;
          fault_d = 1'b0;
          retry_d = 8'd0;
        end else begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (retry_q < 8'(RETRY_MAX)) begin
            retry_d   = retry_q + 8'd1;
            pending_d = 1'b1;
          end else begin
            fault_d = 1'b1;
            retry_d = 8'd0;
          end
        end
      end
      S_HOLD: begin
        if (ms_tick) begin
          if (gap_q == 16'(MIN_GAP_MS - 1)) state_d = S_IDLE;
          else                               gap_d   = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // New requests win over the START clear, so nothing arriving mid-flight is lost.
    if (req_manual || auto_fire) pending_d = 1'b1;

    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      auto_q      <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      pending_q   <= 1'b0;
      retry_q     <= '0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      hi_q        <= '0;
      hd_q        <= '0;
      ti_q        <= '0;
      td_q        <= '0;
      dv_q        <= 1'b0;
      fault_q     <= 1'b0;
      err_q       <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      auto_q      <= auto_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      pending_q   <= pending_d;
      retry_q     <= retry_d;
      cap_data_q  <= cap_data_d;
      cap_valid_q <= cap_valid_d;
      hi_q        <= hi_d;
      hd_q        <= hd_d;
      ti_q        <= ti_d;
      td_q        <= td_d;
      dv_q        <= dv_d;
      fault_q     <= fault_d;
      err_q       <= err_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  assign unit_start   = start_q;
  assign humidity_int = hi_q;
  assign humidity_dec = hd_q;
  assign temp_int     = ti_q;
  assign temp_dec     = td_q;
  assign data_valid   = dv_q;
  assign fault        = fault_q;
  assign err_count    = err_q;
  assign busy         = busy_q;
  assign state        = state_q;

endmodule

// File: doc/dht11_read_scheduler.md
DHT11_READ_SCHEDULER -- requirements
Module: dht11_read_scheduler

Interface
REQ-001 Parameter MIN_GAP_MS, default 2000: minimum ms between the end of one read attempt and the next start.
REQ-002 Parameter AUTO_PERIOD_MS, default 2000: auto-poll request period in ms.
REQ-003 Parameter TIMEOUT_MS, default 50: maximum ms from unit_start to unit_done.
REQ-004 Parameter RETRY_MAX, default 3: retries allowed after a failed attempt.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high, with ports clk and rst.
REQ-006 Ports SHALL be:
- clk  in  1  system clock.
- rst  in  1  async active-high reset.
- tick_1us  in  1  one-cycle 1 MHz tick pulse.
- req_manual  in  1  one-cycle debounced read request.
- auto_en  in  1  level; enables auto-poll.
- unit_start  out  1  one-cycle start pulse to the sensor controller unit.
- unit_done  in  1  one-cycle frame-complete pulse.
- unit_valid  in  1  frame-ok flag, sampled with unit_done.
- unit_data  in  40  raw frame {RH_int, RH_dec, T_int, T_dec, csum}.
- humidity_int, humidity_dec, temp_int, temp_dec  out  8 each  last good reading.
- data_valid  out  1  at least one good reading latched.
- fault  out  1  retries exhausted.
- err_count  out  8  failed attempts, saturating.
- busy  out  1  state != IDLE.
- state  out  3  encoded FSM state.

Function
REQ-007 The block SHALL derive an internal ms_tick every 1000 tick_1us pulses from a free-running prescaler.
REQ-008 The FSM SHALL have these states and encodings: IDLE=0, START=1, WAIT=2, CHECK=3, HOLD=4.
REQ-009 req_manual, or auto-timer expiry, SHALL set a single pending flag.
- Requests arriving while pending is already set SHALL be coalesced (no queue).
REQ-010 Auto-timer behaviour:
- Counts ms_tick while auto_en=1.
- Sets pending and restarts from 0 at AUTO_PERIOD_MS.
- Held at 0 while auto_en=0.
REQ-011 IDLE: if pending=1, go to START on the next clock.
REQ-012 START: lasts exactly one cycle with unit_start=1.
- Clears pending, unless a new request arrives in the same cycle, in which case pending stays 1.
- Clears the timeout counter.
- Next state is WAIT.
REQ-013 WAIT:
- On unit_done, capture unit_data and unit_valid, then go to CHECK.
- Otherwise, at TIMEOUT_MS ms_ticks, go to CHECK as a failure.
- unit_done and the timeout in the same cycle SHALL resolve to unit_done.
REQ-014 CHECK lasts one cycle. Success requires both:
- unit_valid=1.
- (sum of bytes [39:8]) mod 256 == byte [7:0].
REQ-015 On success, the registers listed below SHALL update on the CHECK->HOLD edge:
- humidity_int=[39:32], humidity_dec=[31:24], temp_int=[23:16], temp_dec=[15:8].
- data_valid=1, fault=0, retry_cnt=0.
REQ-016 On failure:
- err_count increments, saturating at 255.
- Data outputs are unchanged.
- If retry_cnt < RETRY_MAX: retry_cnt++ and pending=1.
- Otherwise: fault=1, retry_cnt=0, and pending is left unchanged.
REQ-017 HOLD: load the gap counter on entry, count MIN_GAP_MS ms_ticks, then go to IDLE.
- Requests arriving during HOLD are retained in pending.
REQ-018 unit_done outside WAIT SHALL be ignored.
REQ-019 fault SHALL clear only on a subsequent successful read or on reset.
REQ-020 All outputs SHALL be registered; busy SHALL equal (state != IDLE) in the same cycle.

Reset
REQ-021 While rst=1, the registers listed below SHALL be forced asynchronously:
- state=IDLE, unit_start=0.
- All data outputs=0, data_valid=0, fault=0, err_count=0.
- pending=0, retry_cnt=0, all counters=0.
REQ-022 Reset asserted in any state, including mid-WAIT, SHALL abort the attempt with no output update.
- The first unit_start after release SHALL require a new request.

Verification
(Bench settings: tick_1us high every cycle; MIN_GAP_MS=2, TIMEOUT_MS=3, RETRY_MAX=2, AUTO_PERIOD_MS=10.)
REQ-023 Good frame: req_manual pulse, then unit_done with unit_valid=1 and unit_data=40'h3C_00_19_05_5A.
- Expect humidity_int=60, humidity_dec=0, temp_int=25, temp_dec=5.
- Expect data_valid=1, err_count=0, and exactly one unit_start.
REQ-024 Bad checksum: unit_data=40'h3C_00_19_05_00 on every attempt.
- Expect 3 unit_start pulses, each at least 2000 cycles after the previous attempt ends.
- Expect err_count=3, fault=1, and data outputs unchanged.
REQ-025 Timeout: unit_done never asserted.
- Each WAIT exits after 3000 cycles.
- Expect err_count=3 and fault=1; a following good frame clears fault.
REQ-026 Coalescing: 3 req_manual pulses during WAIT/HOLD.
- Expect exactly one extra unit_start, issued after HOLD completes.
REQ-027 Auto-poll and reset:
- With auto_en=1 and good frames, unit_start recurs about every 10000 cycles.
- rst asserted mid-WAIT zeroes all outputs; no unit_start follows until a new request.
